ccd_stable_capture: RTL and testbench
=====================================

// Module: ccd_stable_capture
// PURPOSE
//  Destination-domain stage placed directly after a multi-bit CDC synchronizer.
//  Synchronized bits arrive unrelated to one another, so a bus may show mixed
//  old/new bits for a few cycles. This block qualifies a value only once it has
//  held steady, and publishes each new stable value over a valid/ready handshake.
//  It also reports how many qualified values were superseded before delivery.
// PARAMETERS
//  WIDTH         8  data width; matches the upstream synchronizer width
//  STABLE_CYCLES 4  consecutive matching compares required to qualify (>=1);
//                   the value must be sampled on STABLE_CYCLES+1 consecutive cycles
//  CNT_WIDTH     8  width of the missed-value counter
//  RESET_VALUE   0  published/last value after reset (WIDTH bits)
// PORTS
//  clock_in      in   1          destination-domain clock
//  reset_in      in   1          asynchronous reset, active-high
//  input_in      in   WIDTH      synchronized (possibly incoherent) bus
//  data_out      out  WIDTH      published value; held while valid_out=1
//  valid_out     out  1          data_out holds an undelivered new value
//  ready_in      in   1          consumer accepts data_out when valid_out=1
//  stable_out    out  WIDTH      most recently qualified value (level view)
//  missed_out    out  CNT_WIDTH  saturating count of superseded qualified values
//  missed_clr_in in   1          synchronous clear of missed_out
// BEHAVIOUR
//  Reset (async): samp_r=RESET_VALUE, run_cnt=0, last_r=stable_out=RESET_VALUE,
//   data_out=RESET_VALUE, valid_out=0, missed_out=0, state=TRACK.
//  Sampler: samp_r<=input_in every cycle. If input_in!=samp_r, run_cnt<=0.
//   Otherwise run_cnt increments and saturates at STABLE_CYCLES.
//  qual = (input_in==samp_r) && (run_cnt==STABLE_CYCLES-1). qual fires exactly
//   once per stable run; cand=input_in at that cycle.
//  event = qual && (cand!=last_r). On qual: last_r<=cand (stable_out follows).
//  FSM, all outputs registered:
//   TRACK: event -> data_out<=cand, valid_out<=1, go PEND. Otherwise hold.
//   PEND, handshake (valid_out&&ready_in):
//     event                -> data_out<=cand, stay PEND (back-to-back)
//     else last_r!=data_out -> data_out<=last_r, stay PEND (catch-up)
//     else                  -> valid_out<=0, go TRACK
//   PEND, no handshake: data_out and valid_out hold. event -> missed_out+1.
//  Latency: input steady from cycle t0 -> qual at t0+STABLE_CYCLES ->
//   valid_out/data_out updated at t0+STABLE_CYCLES+1.
//  Guarantee: after the input stays quiet and handshakes complete, the last
//   delivered data_out equals stable_out.
//  missed_out saturates at all-ones. If missed_clr_in and an increment occur in
//   the same cycle, the clear wins (result 0).
//  A value equal to last_r never produces an event. This includes input equal to
//   RESET_VALUE right after reset.
//  ready_in is ignored when valid_out=0. Reset mid-handshake drops the pending
//   value; no delivery is made.
// TESTING
//  1 STABLE=4, reset, input 0x00 held -> valid_out stays 0, stable_out=0x00.
//  2 input 0x00->0x5A at t0, ready_in=1 -> valid_out=1, data_out=0x5A at t0+5.
//    Handshake drops valid_out at t0+6.
//  3 input toggles 0x5A/0xA5 every 2 cycles for 20 cycles, then holds 0x5A
//    -> no event, valid_out stays 0, missed_out=0.
//  4 ready_in=0, qualify 0x11, then 0x22, then 0x33 -> data_out=0x11, missed_out=2.
//    Raise ready_in: 0x11 accepted, then data_out=0x33 delivered, then valid_out=0.
//  5 ready_in=1, qualify 0x44 with its qual in the same cycle as the 0x33
//    handshake -> data_out=0x44 next cycle, valid_out stays 1.
//  6 reset_in pulsed while valid_out=1 -> all outputs reset immediately
//    (asynchronously). Force missed_out to max with increment+clear in the same
//    cycle -> missed_out=0.

Source files
------------

// File: rtl/ccd_stable_capture.sv
// Post-CDC stability qualifier: accepts a multi-bit synchronized bus only after it has
// held steady, and publishes each newly stable value over valid/ready.
module ccd_stable_capture #(
    parameter int unsigned           WIDTH         = 8,
    parameter int unsigned           STABLE_CYCLES = 4,
    parameter int unsigned           CNT_WIDTH     = 8,
    parameter logic [WIDTH-1:0]      RESET_VALUE   = '0
) (
    input  logic                 clock_in,
    input  logic                 reset_in,
    input  logic [WIDTH-1:0]     input_in,
    output logic [WIDTH-1:0]     data_out,
    output logic                 valid_out,
    input  logic                 ready_in,
    output logic [WIDTH-1:0]     stable_out,
    output logic [CNT_WIDTH-1:0] missed_out,
    input  logic                 missed_clr_in
);

    localparam int unsigned RUN_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [RUN_W-1:0] RUN_MAX  = RUN_W'(STABLE_CYCLES);
    localparam logic [RUN_W-1:0] QUAL_CNT = RUN_W'(STABLE_CYCLES - 1);

    typedef enum logic {
        TRACK = 1'b0,
        PEND  = 1'b1
    } state_t;

    state_t               state_q;
    state_t               state_d;
    logic [WIDTH-1:0]     samp_r;
    logic [RUN_W-1:0]     run_cnt;
    logic [WIDTH-1:0]     last_r;
    logic [WIDTH-1:0]     data_d;
    logic                 valid_d;
    logic [CNT_WIDTH-1:0] missed_d;
    logic                 miss_inc;
    logic                 match;
    logic                 qual;
    logic                 new_val;
    logic                 handshake;

    assign match     = (input_in == samp_r);
    assign qual      = match && (run_cnt == QUAL_CNT);
    assign new_val   = qual && (input_in != last_r);
    assign handshake = valid_out && ready_in;
    assign stable_out = last_r;

    // Run-length sampler; the counter saturates so qual fires once per steady run.
    always_ff @(posedge clock_in or posedge reset_in) begin
        if (reset_in) begin
            samp_r  <= RESET_VALUE;
            run_cnt <= '0;
        end else begin
            samp_r <= input_in;
            if (!match) begin
                run_cnt <= '0;
            end else if (run_cnt != RUN_MAX) begin
                run_cnt <= run_cnt + RUN_W'(1);
            end
        end
    end

    always_ff @(posedge clock_in or posedge reset_in) begin
        if (reset_in) begin
            last_r <= RESET_VALUE;
        end else if (qual) begin
            last_r <= input_in;
        end
    end

    always_ff @(posedge clock_in or posedge reset_in) begin
        if (reset_in) begin
            state_q <= TRACK;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            TRACK: begin
                if (new_val) begin
                    state_d = PEND;
                end
            end
            PEND: begin
                if (handshake && !new_val && (last_r == data_out)) begin
                    state_d = TRACK;
                end
            end
            default: state_d = TRACK;
        endcase
    end

    // Next values for the registered outputs; a handshake refills from the newest stable value.
    always_comb begin
        data_d   = data_out;
        valid_d  = valid_out;
        missed_d = missed_out;
        miss_inc = 1'b0;
        case (state_q)
            TRACK: begin
                if (new_val) begin
                    data_d  = input_in;
                    valid_d = 1'b1;
                end
            end
            PEND: begin
                if (handshake) begin
                    if (new_val) begin
                        data_d = input_in;
                    end else if (last_r != data_out) begin
                        data_d = last_r;
                    end else begin
                        valid_d = 1'b0;
                    end
                end else if (new_val) begin
                    miss_inc = 1'b1;
                end
            end
            default: begin
                valid_d = 1'b0;
            end
        endcase
        if (missed_clr_in) begin
            missed_d = '0;
        end else if (miss_inc && (missed_out != '1)) begin
            missed_d = missed_out + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clock_in or posedge reset_in) begin
        if (reset_in) begin
            data_out   <= RESET_VALUE;
            valid_out  <= 1'b0;
            missed_out <= '0;
        end else begin
            data_out   <= data_d;
            valid_out  <= valid_d;
            missed_out <= missed_d;
        end
    end

endmodule

// File: tb/tb_ccd_stable_capture.sv
// Bench for ccd_stable_capture: fixed vector table, directed corner sequences and
// randomized bursty input checked against a run-length based reference model.
module tb_ccd_stable_capture;

    localparam int unsigned WIDTH  = 8;
    localparam int unsigned STABLE = 4;
    localparam int unsigned CNT_W  = 8;
    localparam logic [7:0]  RST_VAL = 8'h00;

    typedef struct {
        logic [7:0] din;
        logic       rdy;
        logic       exp_v;
        logic [7:0] exp_d;
        logic [7:0] exp_s;
        logic [7:0] exp_m;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] din;
    logic       rdy;
    logic       clr;
    logic [7:0] dout;
    logic       vout;
    logic [7:0] sout;
    logic [7:0] mout;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    logic [7:0] m_prev;
    int         m_len;
    logic [7:0] m_last;
    logic [7:0] m_data;
    logic       m_valid;
    logic [7:0] m_missed;

    logic [7:0] last_acc;
    vec_t       vecs [13];

    ccd_stable_capture #(
        .WIDTH(WIDTH),
        .STABLE_CYCLES(STABLE),
        .CNT_WIDTH(CNT_W),
        .RESET_VALUE(RST_VAL)
    ) dut (
        .clock_in(clk),
        .reset_in(rst),
        .input_in(din),
        .data_out(dout),
        .valid_out(vout),
        .ready_in(rdy),
        .stable_out(sout),
        .missed_out(mout),
        .missed_clr_in(clr)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_prev   = RST_VAL;
        m_len    = 1;
        m_last   = RST_VAL;
        m_data   = RST_VAL;
        m_valid  = 1'b0;
        m_missed = 8'h00;
    endtask

    // A value qualifies on the cycle its run of identical samples reaches STABLE+1.
    task automatic model_step();
        logic       q;
        logic       ev;
        logic       inc;
        logic [7:0] old_last;
        if (din == m_prev) begin
            if (m_len < STABLE + 2) m_len = m_len + 1;
        end else begin
            m_len = 1;
        end
        m_prev   = din;
        q        = (m_len == STABLE + 1);
        ev       = q && (din != m_last);
        old_last = m_last;
        inc      = 1'b0;
        if (!m_valid) begin
            if (ev) begin
                m_data  = din;
                m_valid = 1'b1;
            end
        end else if (rdy) begin
            if (ev) m_data = din;
            else if (old_last != m_data) m_data = old_last;
            else m_valid = 1'b0;
        end else if (ev) begin
            inc = 1'b1;
        end
        if (q) m_last = din;
        if (clr) m_missed = 8'h00;
        else if (inc && m_missed != 8'hFF) m_missed = m_missed + 8'd1;
    endtask

    task automatic check(input string name, input logic ev, input logic [7:0] ed,
                         input logic [7:0] es, input logic [7:0] em);
        n_checks++;
        if (vout !== ev || dout !== ed || sout !== es || mout !== em) begin
            n_fail++;
            $display("FAIL %s: got valid=%0b data=%h stable=%h missed=%0d, want valid=%0b data=%h stable=%h missed=%0d",
                     name, vout, dout, sout, mout, ev, ed, es, em);
        end
    endtask

    task automatic check_val(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic step();
        if (vout && rdy) last_acc = dout;
        @(posedge clk);
        #1;
        model_step();
    endtask

    task automatic hold(input logic [7:0] v, input int n, input logic r, input logic clr_last);
        for (int i = 0; i < n; i++) begin
            din = v;
            rdy = r;
            clr = clr_last && (i == n - 1);
            step();
        end
        clr = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        din = RST_VAL;
        rdy = 1'b0;
        clr = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        check("reset_state", 1'b0, RST_VAL, RST_VAL, 8'h00);
        rst = 1'b0;
        model_reset();
        last_acc = RST_VAL;
    endtask

    initial begin
        rst = 1'b1;
        din = RST_VAL;
        rdy = 1'b0;
        clr = 1'b0;
        last_acc = RST_VAL;
        model_reset();

        // idle at reset value, then 0x5A from cycle 6 with ready held high
        for (int i = 0; i < 6; i++) vecs[i] = '{8'h00, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00};
        for (int i = 6; i < 10; i++) vecs[i] = '{8'h5A, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00};
        vecs[10] = '{8'h5A, 1'b1, 1'b1, 8'h5A, 8'h5A, 8'h00};
        vecs[11] = '{8'h5A, 1'b1, 1'b0, 8'h5A, 8'h5A, 8'h00};
        vecs[12] = '{8'h5A, 1'b1, 1'b0, 8'h5A, 8'h5A, 8'h00};

        do_reset();
        for (int i = 0; i < 13; i++) begin
            din = vecs[i].din;
            rdy = vecs[i].rdy;
            step();
            check($sformatf("vec%0d", i), vecs[i].exp_v, vecs[i].exp_d, vecs[i].exp_s, vecs[i].exp_m);
        end

        // incoherent toggling never qualifies
        for (int k = 0; k < 10; k++) hold((k % 2 == 0) ? 8'hA5 : 8'h5A, 2, 1'b1, 1'b0);
        hold(8'h5A, 8, 1'b1, 1'b0);
        check("toggle_no_event", 1'b0, 8'h5A, 8'h5A, 8'h00);

        // superseded values while stalled, then catch-up delivery
        hold(8'h11, 6, 1'b0, 1'b0);
        check("stall_first", 1'b1, 8'h11, 8'h11, 8'h00);
        hold(8'h22, 6, 1'b0, 1'b0);
        hold(8'h33, 6, 1'b0, 1'b0);
        check("stall_missed", 1'b1, 8'h11, 8'h33, 8'h02);
        hold(8'h33, 1, 1'b1, 1'b0);
        check("catchup_load", 1'b1, 8'h33, 8'h33, 8'h02);
        check_val("accepted_11", last_acc, 8'h11);
        hold(8'h33, 1, 1'b1, 1'b0);
        check("catchup_done", 1'b0, 8'h33, 8'h33, 8'h02);
        check_val("accepted_33", last_acc, 8'h33);

        // qualification coinciding with a handshake
        do_reset();
        hold(8'h33, 6, 1'b0, 1'b0);
        check("b2b_pending", 1'b1, 8'h33, 8'h33, 8'h00);
        hold(8'h44, 4, 1'b0, 1'b0);
        check("b2b_before", 1'b1, 8'h33, 8'h33, 8'h00);
        hold(8'h44, 1, 1'b1, 1'b0);
        check("b2b_load", 1'b1, 8'h44, 8'h44, 8'h00);
        check_val("b2b_accepted_33", last_acc, 8'h33);
        hold(8'h44, 1, 1'b1, 1'b0);
        check("b2b_done", 1'b0, 8'h44, 8'h44, 8'h00);

        // asynchronous reset while a value is pending
        hold(8'h66, 6, 1'b0, 1'b0);
        check("pre_async", 1'b1, 8'h66, 8'h66, 8'h00);
        rdy = 1'b1;
        #2 rst = 1'b1;
        #1;
        check("async_reset", 1'b0, RST_VAL, RST_VAL, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        hold(8'h00, 6, 1'b1, 1'b0);
        check("after_async", 1'b0, RST_VAL, RST_VAL, 8'h00);

        // missed counter saturation, then clear racing an increment
        for (int i = 0; i < 256; i++) hold((i % 2 == 0) ? 8'h77 : 8'h88, 5, 1'b0, 1'b0);
        check("missed_max", 1'b1, 8'h77, 8'h88, 8'hFF);
        hold(8'h77, 5, 1'b0, 1'b0);
        check("missed_sat", 1'b1, 8'h77, 8'h77, 8'hFF);
        hold(8'h88, 5, 1'b0, 1'b1);
        check("clear_wins", 1'b1, 8'h77, 8'h88, 8'h00);

        // randomized bursty input against the reference model
        do_reset();
        begin
            int         left;
            logic [7:0] v;
            left = 0;
            v    = 8'h00;
            for (int i = 0; i < 3000; i++) begin
                if (left == 0) begin
                    left = int'($urandom_range(1, 8));
                    if ($urandom_range(0, 3) == 0) v = 8'($urandom_range(0, 255));
                    else v = 8'($urandom_range(0, 3)) * 8'h31;
                end
                left--;
                din = v;
                rdy = ($urandom_range(0, 99) < 40);
                clr = ($urandom_range(0, 99) < 3);
                step();
                check("rand", m_valid, m_data, m_last, m_missed);
            end
            clr = 1'b0;
            hold(v, 16, 1'b1, 1'b0);
            check("quiet", m_valid, m_data, m_last, m_missed);
            check_val("delivered_is_stable", last_acc, m_last);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
